// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: MIPS IF stage owning the PC, addressing the instruction ROM and loading IF/ID.
// Ports: clk/rst (async active-high); fetch_en parks the unit in IDLE when low;
// pc drives the combinational ROM, inst returns the ROM word in the same cycle;
// stall holds PC and IF/ID; branch_taken/branch_target (EX) outrank jump/jump_target (ID);
// if_id_inst/if_id_pc/if_id_valid form the IF/ID register (if_id_pc is PC+1).
// Optional FETCH_PERF_CNT_EN adds saturating fetch_cnt, stall_cnt and flush_cnt.
module inst_fetch_unit #(
  parameter int PC_W = 5,
  parameter int INST_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [INST_W-1:0] NOP_INST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic [PC_W-1:0]   pc,
  input  logic [INST_W-1:0] inst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  input  logic              jump,
  input  logic [PC_W-1:0]   jump_target,
  output logic [INST_W-1:0] if_id_inst,
  output logic [PC_W-1:0]   if_id_pc,
  output logic              if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, if_id_pc_q, if_id_pc_d, pc_inc;
  logic [INST_W-1:0] if_id_inst_q, if_id_inst_d;
  logic if_id_valid_q, if_id_valid_d, redirect, hold, seq;
  always_comb begin
    pc_inc = pc_q + PC_W'(1);
    redirect = state_q == RUN && (branch_taken || jump);
    hold = state_q == RUN && stall && !redirect;
    seq = state_q == RUN && !stall && !redirect;
    // branch is older than jump, so it wins when both redirect on one edge
    pc_d = redirect ? (branch_taken ? branch_target : jump_target) : seq ? pc_inc : pc_q;
    if_id_inst_d = seq ? inst : hold ? if_id_inst_q : NOP_INST;
    if_id_pc_d = seq ? pc_inc : hold ? if_id_pc_q : '0;
    if_id_valid_d = seq || (hold && if_id_valid_q);
    // a pending stall keeps the unit in RUN even once fetch_en drops
    state_d = state_q == IDLE ? (fetch_en ? RUN : IDLE) : (!fetch_en && !stall ? IDLE : RUN);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      if_id_inst_q <= NOP_INST;
      if_id_pc_q <= '0;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      if_id_inst_q <= if_id_inst_d;
      if_id_pc_q <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end
  assign pc = pc_q;
  assign if_id_inst = if_id_inst_q;
  assign if_id_pc = if_id_pc_q;
  assign if_id_valid = if_id_valid_q;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 16'(seq && ~&fetch_cnt_q);
    stall_cnt_d = stall_cnt_q + 16'(hold && ~&stall_cnt_q);
    flush_cnt_d = flush_cnt_q + 16'(redirect && ~&flush_cnt_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: randomized and directed bench for inst_fetch_unit against a cycle-level reference model.
module tb_inst_fetch_unit;
  logic clk = 1'b0, rst = 1'b1, fetch_en = 1'b0, stall = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic [4:0] branch_target = '0, jump_target = '0, pc, if_id_pc;
  logic [31:0] inst, if_id_inst;
  logic if_id_valid;
  logic [31:0] rom [32];
  int checks = 0, failures = 0;
  logic m_run, m_val;
  logic [4:0] m_pc, m_ipc;
  logic [31:0] m_inst;
  int m_fc, m_sc, m_xc;
  logic [42:0] obs;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt, stall_cnt, flush_cnt;
`endif
  inst_fetch_unit dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc(pc), .inst(inst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump),
    .jump_target(jump_target), .if_id_inst(if_id_inst), .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );
  always #5 clk = ~clk;
  assign inst = rom[pc];
  assign obs = {pc, if_id_inst, if_id_pc, if_id_valid};
  task automatic model_reset();
    m_run = 1'b0; m_val = 1'b0; m_pc = '0; m_ipc = '0; m_inst = '0;
    m_fc = 0; m_sc = 0; m_xc = 0;
  endtask
  task automatic step();
    if (!m_run) begin
      m_inst = '0; m_ipc = '0; m_val = 1'b0;
      m_run = fetch_en;
    end else begin
      if (branch_taken || jump) begin
        m_pc = branch_taken ? branch_target : jump_target;
        m_inst = '0; m_ipc = '0; m_val = 1'b0;
        if (m_xc < 65535) m_xc++;
      end else if (stall) begin
        if (m_sc < 65535) m_sc++;
      end else begin
        m_inst = rom[m_pc];
        m_pc = 5'((int'(m_pc) + 1) % 32);
        m_ipc = m_pc; m_val = 1'b1;
        if (m_fc < 65535) m_fc++;
      end
      if (!fetch_en && !stall) m_run = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (obs !== 43'd0) begin failures++; $display("FAIL reset got=%h want=0", obs); end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if ({fetch_cnt, stall_cnt, flush_cnt} !== 48'd0) begin failures++; $display("FAIL reset_cnt got=%h want=0", {fetch_cnt, stall_cnt, flush_cnt}); end
`endif
    rst = 1'b0;
    model_reset();
  endtask
  task automatic test_refill();
    for (int k = 0; k < 32; k++) rom[k] = 32'h100 + k;
    fetch_en = 1'b1;
    step();
    checks++;
    if ({pc, if_id_inst, if_id_valid} !== {5'd0, 32'd0, 1'b0}) begin failures++; $display("FAIL refill_e1 got=%h want=0", {pc, if_id_inst, if_id_valid}); end
    step();
    checks++;
    if (obs !== {5'd1, 32'h100, 5'd1, 1'b1}) begin failures++; $display("FAIL refill_e2 got=%h want=%h", obs, {5'd1, 32'h100, 5'd1, 1'b1}); end
    step();
    checks++;
    if (obs !== {5'd2, 32'h101, 5'd2, 1'b1}) begin failures++; $display("FAIL refill_e3 got=%h want=%h", obs, {5'd2, 32'h101, 5'd2, 1'b1}); end
  endtask
  task automatic test_stall();
    for (int i = 0; i < 8 && m_pc != 5'd5; i++) begin
      step();
      checks++;
      if (obs !== {m_pc, m_inst, m_ipc, m_val}) begin failures++; $display("FAIL stall_run got=%h want=%h", obs, {m_pc, m_inst, m_ipc, m_val}); end
    end
    stall = 1'b1;
    step(); step();
    checks++;
    if ({pc, if_id_inst, if_id_valid} !== {5'd5, 32'h104, 1'b1}) begin failures++; $display("FAIL stall_hold got=%h want=%h", {pc, if_id_inst, if_id_valid}, {5'd5, 32'h104, 1'b1}); end
    stall = 1'b0;
    step();
    checks++;
    if (obs !== {5'd6, 32'h105, 5'd6, 1'b1}) begin failures++; $display("FAIL stall_resume got=%h want=%h", obs, {5'd6, 32'h105, 5'd6, 1'b1}); end
  endtask
  task automatic test_branch();
    for (int i = 0; i < 8 && m_pc != 5'h0A; i++) step();
    branch_taken = 1'b1; branch_target = 5'h0B;
    step();
    branch_taken = 1'b0;
    checks++;
    if ({pc, if_id_inst, if_id_valid} !== {5'h0B, 32'd0, 1'b0}) begin failures++; $display("FAIL branch_bubble got=%h want=%h", {pc, if_id_inst, if_id_valid}, {5'h0B, 32'd0, 1'b0}); end
    step();
    checks++;
    if (obs !== {5'h0C, 32'h10B, 5'h0C, 1'b1}) begin failures++; $display("FAIL branch_target got=%h want=%h", obs, {5'h0C, 32'h10B, 5'h0C, 1'b1}); end
  endtask
  task automatic test_combo();
    jump = 1'b1; jump_target = 5'h09; branch_taken = 1'b1; branch_target = 5'h03; stall = 1'b1;
    step();
    jump = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    checks++;
    if ({pc, if_id_inst, if_id_valid} !== {5'h03, 32'd0, 1'b0}) begin failures++; $display("FAIL combo_prio got=%h want=%h", {pc, if_id_inst, if_id_valid}, {5'h03, 32'd0, 1'b0}); end
    step();
    checks++;
    if (obs !== {5'h04, 32'h103, 5'h04, 1'b1}) begin failures++; $display("FAIL combo_refill got=%h want=%h", obs, {5'h04, 32'h103, 5'h04, 1'b1}); end
  endtask
  task automatic test_wrap();
    for (int i = 0; i < 40 && m_pc != 5'h1F; i++) begin
      step();
      checks++;
      if (obs !== {m_pc, m_inst, m_ipc, m_val}) begin failures++; $display("FAIL wrap_run got=%h want=%h", obs, {m_pc, m_inst, m_ipc, m_val}); end
    end
    step();
    checks++;
    if (obs !== {5'h00, 32'h11F, 5'h00, 1'b1}) begin failures++; $display("FAIL wrap got=%h want=%h", obs, {5'h00, 32'h11F, 5'h00, 1'b1}); end
  endtask
  task automatic test_idle_redirect();
    logic [4:0] held;
    fetch_en = 1'b0;
    step();
    held = pc;
    branch_taken = 1'b1; branch_target = 5'h10; jump = 1'b1; jump_target = 5'h12;
    step(); step();
    branch_taken = 1'b0; jump = 1'b0;
    checks++;
    if ({pc, if_id_inst, if_id_valid} !== {held, 32'd0, 1'b0} || pc !== m_pc) begin failures++; $display("FAIL idle_redirect got=%h want=%h", {pc, if_id_inst, if_id_valid}, {held, 32'd0, 1'b0}); end
  endtask
  task automatic test_random();
    for (int k = 0; k < 32; k++) rom[k] = $urandom;
    for (int i = 0; i < 400; i++) begin
      fetch_en = $urandom_range(0, 99) < 85;
      stall = $urandom_range(0, 99) < 20;
      branch_taken = $urandom_range(0, 99) < 10;
      jump = $urandom_range(0, 99) < 10;
      branch_target = 5'($urandom);
      jump_target = 5'($urandom);
      step();
      checks++;
      if (obs !== {m_pc, m_inst, m_ipc, m_val}) begin failures++; $display("FAIL random[%0d] got=%h want=%h", i, obs, {m_pc, m_inst, m_ipc, m_val}); end
    end
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if ({fetch_cnt, stall_cnt, flush_cnt} !== {16'(m_fc), 16'(m_sc), 16'(m_xc)}) begin failures++; $display("FAIL random_cnt got=%h want=%h", {fetch_cnt, stall_cnt, flush_cnt}, {16'(m_fc), 16'(m_sc), 16'(m_xc)}); end
`endif
  endtask
  task automatic test_reset_mid_stall();
    fetch_en = 1'b1; branch_taken = 1'b1; branch_target = 5'd7; stall = 1'b0; jump = 1'b0;
    for (int i = 0; i < 4 && !(m_run && m_pc == 5'd7); i++) step();
    branch_taken = 1'b0; stall = 1'b1;
    step(); step();
    checks++;
    if (pc !== 5'd7 || pc !== m_pc) begin failures++; $display("FAIL mid_stall_pc got=%h want=07", pc); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== 43'd0) begin failures++; $display("FAIL async_reset got=%h want=0", obs); end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if ({fetch_cnt, stall_cnt, flush_cnt} !== 48'd0) begin failures++; $display("FAIL async_reset_cnt got=%h want=0", {fetch_cnt, stall_cnt, flush_cnt}); end
`endif
    stall = 1'b0; fetch_en = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
  endtask
  initial begin
    for (int k = 0; k < 32; k++) rom[k] = 32'h100 + k;
    model_reset();
    test_reset();
    test_refill();
    test_stall();
    test_branch();
    test_combo();
    test_wrap();
    test_idle_redirect();
    test_random();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, and the reader side of the instruction ROM.
- Owns the PC, drives the word address to the combinational instruction ROM, and captures the returned word into the IF/ID register.
- Honours load-use stalls from hazard detection, and redirects/flushes from branch resolution (EX) and jump decode (ID).

Parameters:
- PC_W, 5, word-address width of PC and ROM index.
- INST_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INST, 32'h00000000, bubble encoding inserted on flush or idle.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- fetch_en  in  1  start/continue fetching; low parks the unit in IDLE.
- pc  out  PC_W  ROM address, driven directly from the PC register.
- inst  in  INST_W  ROM data for pc, combinational same cycle.
- stall  in  1  load-use stall: hold PC and IF/ID.
- branch_taken  in  1  EX-stage branch resolved taken.
- branch_target  in  PC_W  word target for a taken branch.
- jump  in  1  ID-stage J-type decoded.
- jump_target  in  PC_W  word target for the jump (low PC_W bits of instr_index).
- if_id_inst  out  INST_W  registered instruction to ID.
- if_id_pc  out  PC_W  registered PC+1 of that instruction.
- if_id_valid  out  1  IF/ID holds a real, non-flushed instruction.

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect): PC=RESET_PC, if_id_inst=NOP_INST, if_id_pc=0, if_id_valid=0, FSM=IDLE.
- FSM states:
  - IDLE: PC holds; IF/ID loads NOP, valid=0. Moves to RUN on the next edge when fetch_en=1.
  - RUN: normal fetch. Moves to IDLE on an edge with fetch_en=0 and stall=0. While stall=1 the unit stays in RUN until the stall clears.
- Per-edge priority in RUN: branch_taken > jump > stall > sequential.
  - branch_taken: PC<=branch_target; IF/ID<=NOP, valid=0. A simultaneous jump is ignored because the branch is older. A simultaneous stall is overridden.
  - jump (no branch): PC<=jump_target; IF/ID<=NOP, valid=0. A simultaneous stall is overridden.
  - stall: PC, if_id_inst, if_id_pc and if_id_valid all hold.
  - sequential: if_id_inst<=inst, if_id_pc<=PC+1, valid=1, PC<=PC+1.
- PC+1 is modulo 2^PC_W: 31 wraps to 0, with no error flag.
- Latency: a word at PC appears on if_id_inst one edge after pc presents it.
- Pipeline refill: the first valid instruction after reset or IDLE appears 2 edges after fetch_en rises (one edge to enter RUN, one edge to latch).
- Redirect cost is one bubble.
- Redirect while in IDLE: ignored.
- pc output is purely the register; no combinational path from any input.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds:
  - output fetch_cnt[15:0]: counts edges with valid=1 loaded.
  - output stall_cnt[15:0]: counts RUN edges with stall=1 and no redirect.
  - output flush_cnt[15:0]: counts redirect edges.
- All three counters reset to 0, saturate at 16'hFFFF, and are unaffected by fetch_en.
- When undefined, the ports and logic are absent and the base behaviour is identical.

Test Plan:
- Reset, then fetch_en=1 with ROM[k]=k+0x100 → pc goes 0,0,1,2,3; if_id_inst is NOP, NOP, then 0x100/if_id_pc=1, then 0x101/pc=2; valid asserts on the 2nd edge.
- stall=1 for 2 cycles while pc=5 → pc stays 5 and if_id holds ROM[4], valid=1; resumes with ROM[5] on the edge after stall drops.
- branch_taken=1, target=0x0B, at pc=0x0A → next pc=0x0B, if_id_inst=NOP, valid=0; ROM[0x0B] is latched one edge later.
- jump=1, target=0x09, branch_taken=1, target=0x03, plus stall=1, all in the same cycle → pc=0x03 (branch wins), one bubble, stall ignored.
- Sequential run through pc=0x1F → next pc=0x00, if_id_pc=0x00, no glitch in valid.
- Assert rst mid-stall at pc=7 → all outputs return to reset values immediately, before the clock edge. With FETCH_PERF_CNT_EN defined, the counters read 0.
